// File: rtl/udp_pkg.sv
// Shared UDP receive definitions: header sizes, FSM states, header word indices.
package udp_pkg;

    localparam int unsigned UDP_HEAD_N = 8;
    localparam int unsigned PORT_W     = 16;
    localparam int unsigned UDP_LEN_W  = 16;
    localparam int unsigned HDR_IDX_W  = 2;
    localparam int unsigned BYTE_CNT_W = 2;
    localparam int unsigned WORD_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } udp_state_e;

    typedef logic [HDR_IDX_W-1:0] hdr_idx_t;

    // Position of each 16-bit field inside the 8-byte UDP header
    localparam hdr_idx_t HDR_SRC  = 2'd0;
    localparam hdr_idx_t HDR_DST  = 2'd1;
    localparam hdr_idx_t HDR_LEN  = 2'd2;
    localparam hdr_idx_t HDR_CSUM = 2'd3;

    // Registered output word toward the application
    typedef struct packed {
        logic                  valid;
        logic                  start;
        logic                  cancel;
        logic                  drop;
        logic [BYTE_CNT_W-1:0] len;
        logic [WORD_W-1:0]     data;
    } udp_out_t;

    // Header fields are big-endian on the wire; the earlier byte sits in the low lane
    function automatic logic [PORT_W-1:0] hdr_field(input logic [WORD_W-1:0] w);
        return {w[7:0], w[15:8]};
    endfunction

endpackage

// File: rtl/udp_rx_if.sv
// Payload stream from the IPv4 stage and UDP payload stream toward the application.
interface udp_rx_if #(
    parameter int unsigned DATA_W = 16
) ();

    logic              valid_i;
    logic              start_i;
    logic              cancel_i;
    logic [DATA_W-1:0] data_i;
    logic [1:0]        len_i;
    logic              cs_err_i;

    logic              valid_o;
    logic              start_o;
    logic              cancel_o;
    logic [DATA_W-1:0] data_o;
    logic [1:0]        len_o;
    logic              drop_o;

    // Upstream/application side
    modport master (
        output valid_i, start_i, cancel_i, data_i, len_i, cs_err_i,
        input  valid_o, start_o, cancel_o, data_o, len_o, drop_o
    );

    // UDP receiver side
    modport slave (
        input  valid_i, start_i, cancel_i, data_i, len_i, cs_err_i,
        output valid_o, start_o, cancel_o, data_o, len_o, drop_o
    );

endinterface

// File: rtl/udp_port_match.sv
// Port comparator: flags a mismatch only on the header word it is assigned to.
module udp_port_match
    import udp_pkg::*;
#(
    parameter logic [PORT_W-1:0] PORT = '0,
    parameter hdr_idx_t          IDX  = HDR_DST
) (
    input  logic              en,
    input  hdr_idx_t          idx,
    input  logic [PORT_W-1:0] field,
    output logic              mismatch_c
);

    // Mismatch is meaningful only when the selected header word is present
    always_comb begin
        mismatch_c = en && (idx == IDX) && (field != PORT);
    end

endmodule

// File: rtl/udp_rx.sv
// UDP receive filter: parses the 8-byte header, filters on port/length/IP checksum
// and forwards the payload with one cycle of latency.
// Optional build macro UDP_RX_SRC_PORT_MATCH_EN adds a source port filter.
module udp_rx
    import udp_pkg::*;
#(
    parameter int unsigned       DATA_W   = 16,
    parameter logic [PORT_W-1:0] DST_PORT = 16'd5001,
    parameter logic [PORT_W-1:0] SRC_PORT = 16'd5000
) (
    input logic   clk,
    input logic   nreset,
    udp_rx_if.slave bus
);

    localparam logic [UDP_LEN_W-1:0] HEAD_N_L = UDP_LEN_W'(UDP_HEAD_N);

    if (DATA_W != 16 || $bits(DST_PORT) != PORT_W || $bits(SRC_PORT) != PORT_W) begin : g_cfg_err
        $error("udp_rx: only a 16-bit data path with 16-bit ports is supported");
    end

    udp_state_e           state, state_nx;
    hdr_idx_t             hdr_cnt, hdr_cnt_nx;
    logic [UDP_LEN_W-1:0] ulen_q, ulen_nx;
    logic [UDP_LEN_W-1:0] rem, rem_nx;
    logic                 first, first_nx;
    udp_out_t             out_q, out_nx;

    logic [UDP_LEN_W-1:0] field;
    logic [UDP_LEN_W-1:0] len_in;
    logic [UDP_LEN_W-1:0] emit;
    logic                 take;
    logic                 restart;
    logic                 last;
    logic                 len_bad;
    logic                 chk_en;
    hdr_idx_t             idx;
    logic                 dst_bad;
    logic                 src_bad;

    assign field   = hdr_field(bus.data_i);
    assign take    = bus.valid_i & ~bus.cancel_i;
    assign restart = take & bus.start_i;
    assign idx     = restart ? HDR_SRC : hdr_cnt;
    assign chk_en  = restart | (take & (state == HEAD));
    assign len_in  = UDP_LEN_W'(bus.len_i);
    assign last    = (rem <= len_in);
    assign emit    = last ? rem : len_in;
    assign len_bad = (hdr_cnt == HDR_LEN) && (field < HEAD_N_L);

    udp_port_match #(
        .PORT (DST_PORT),
        .IDX  (HDR_DST)
    ) u_dst_match (
        .en         (chk_en),
        .idx        (idx),
        .field      (field),
        .mismatch_c (dst_bad)
    );

`ifdef UDP_RX_SRC_PORT_MATCH_EN
    udp_port_match #(
        .PORT (SRC_PORT),
        .IDX  (HDR_SRC)
    ) u_src_match (
        .en         (chk_en),
        .idx        (idx),
        .field      (field),
        .mismatch_c (src_bad)
    );
`else
    assign src_bad = 1'b0;
`endif

    // State and header/payload bookkeeping registers
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state   <= IDLE;
            hdr_cnt <= HDR_SRC;
            ulen_q  <= '0;
            rem     <= '0;
            first   <= 1'b0;
        end else begin
            state   <= state_nx;
            hdr_cnt <= hdr_cnt_nx;
            ulen_q  <= ulen_nx;
            rem     <= rem_nx;
            first   <= first_nx;
        end
    end

    // Next state: cancel beats start, start restarts the header from any state
    always_comb begin
        state_nx   = state;
        hdr_cnt_nx = hdr_cnt;
        ulen_nx    = ulen_q;
        rem_nx     = rem;
        first_nx   = first;
        if (bus.cancel_i) begin
            state_nx = IDLE;
        end else if (restart) begin
            hdr_cnt_nx = HDR_DST;
            state_nx   = (bus.cs_err_i | src_bad) ? DROP : HEAD;
        end else if (take) begin
            case (state)
                HEAD: begin
                    hdr_cnt_nx = hdr_cnt + 2'd1;
                    if (dst_bad || len_bad) begin
                        state_nx = DROP;
                    end else if (hdr_cnt == HDR_LEN) begin
                        ulen_nx = field;
                    end else if (hdr_cnt == HDR_CSUM) begin
                        if (ulen_q == HEAD_N_L) begin
                            state_nx = IDLE;
                        end else begin
                            state_nx = DATA;
                            rem_nx   = ulen_q - HEAD_N_L;
                            first_nx = 1'b1;
                        end
                    end
                end
                DATA: begin
                    rem_nx   = rem - emit;
                    first_nx = 1'b0;
                    if (last) begin
                        state_nx = IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next output word; data/len hold their last value when nothing is emitted
    always_comb begin
        out_nx        = '0;
        out_nx.data   = out_q.data;
        out_nx.len    = out_q.len;
        out_nx.cancel = bus.cancel_i | (restart & (state == DATA));
        if (restart) begin
            out_nx.drop = bus.cs_err_i | src_bad;
        end else if (take) begin
            case (state)
                HEAD: begin
                    out_nx.drop = dst_bad | len_bad;
                end
                DATA: begin
                    out_nx.valid = 1'b1;
                    out_nx.start = first;
                    out_nx.data  = bus.data_i;
                    out_nx.len   = emit[BYTE_CNT_W-1:0];
                end
                default: begin
                end
            endcase
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (!nreset) begin
            out_q <= '0;
        end else begin
            out_q <= out_nx;
        end
    end

    assign bus.valid_o  = out_q.valid;
    assign bus.start_o  = out_q.start;
    assign bus.cancel_o = out_q.cancel;
    assign bus.drop_o   = out_q.drop;
    assign bus.len_o    = out_q.len;
    assign bus.data_o   = out_q.data;

endmodule

// File: tb/tb_udp_rx.sv
// Randomized scoreboard bench for udp_rx: a packet-level model predicts each output
// event and its cycle; a monitor matches every output the DUT presents.
module tb_udp_rx;

    localparam logic [15:0] DST = 16'd5001;
    localparam logic [15:0] SRC = 16'd5000;

    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    udp_rx_if #(.DATA_W(16)) bus ();

    udp_rx #(
        .DATA_W   (16),
        .DST_PORT (DST),
        .SRC_PORT (SRC)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    typedef struct {
        int          cyc;
        bit          v;
        bit          s;
        bit          c;
        bit          d;
        logic [15:0] data;
        logic [1:0]  len;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;
    bit  pend_cancel = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(bit v, bit s, bit c, bit d, logic [15:0] data, logic [1:0] len);
        ev_t e;
        e.cyc = 0; e.v = v; e.s = s; e.c = c; e.d = d; e.data = data; e.len = len;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected output appears one clock after the word is captured
    task automatic push(input ev_t e);
        e.cyc = cyc + 1;
        q.push_back(e);
    endtask

    task automatic drive(input bit v, input bit s, input bit c, input logic [15:0] d,
                         input logic [1:0] l, input bit cs);
        @(negedge clk);
        bus.valid_i = v; bus.start_i = s; bus.cancel_i = c;
        bus.data_i = d; bus.len_i = l; bus.cs_err_i = cs;
    endtask

    // Random bubbles; start_i/cs_err_i toggled there must be ignored
    task automatic idle_gap();
        if ($urandom % 4 == 0)
            repeat ($urandom_range(1, 2)) drive(1'b0, 1'($urandom), 1'b0, 16'($urandom), 2'd2, 1'($urandom));
    endtask

    task automatic send_word(input logic [15:0] d, input logic [1:0] l, input bit s, input bit cs,
                             input bit has, input ev_t e);
        idle_gap();
        drive(1'b1, s, 1'b0, d, l, cs);
        if (has) push(e);
    endtask

    // cut_kind: 0 none, 1 cancel_i at payload word cut_at, 2 stop after cut_at payload
    // words (next packet restarts in DATA), 3 stop after two header words
    task automatic send_pkt(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] ulen,
                            input bit cs, input int cut_kind, input int cut_at, input int n_pad,
                            input bit force2);
        logic [15:0] hdr[4];
        logic [15:0] w;
        int          drop_at;
        int          rem;
        int          k;
        int          li;
        int          out;
        bit          pc;
        ev_t         e;
        pc = pend_cancel;
        pend_cancel = 1'b0;
        hdr[0] = {src[7:0], src[15:8]};
        hdr[1] = {dst[7:0], dst[15:8]};
        hdr[2] = {ulen[7:0], ulen[15:8]};
        hdr[3] = 16'($urandom);
        drop_at = -1;
        if (cs) drop_at = 0;
`ifdef UDP_RX_SRC_PORT_MATCH_EN
        else if (src != SRC) drop_at = 0;
`endif
        else if (dst != DST) drop_at = 1;
        else if (ulen < 16'd8) drop_at = 2;

        for (int i = 0; i < 4; i++) begin
            if (cut_kind == 3 && i == 2) return;
            e = mk(1'b0, 1'b0, (i == 0) && pc, i == drop_at, 16'h0, 2'd0);
            send_word(hdr[i], 2'd2, i == 0, (i == 0) ? cs : 1'($urandom),
                      ((i == 0) && pc) || (i == drop_at), e);
        end
        if (drop_at >= 0) begin
            repeat (n_pad + 2) send_word(16'($urandom), 2'd2, 1'b0, 1'b0, 1'b0, e);
            return;
        end
        rem = int'(ulen) - 8;
        k = 0;
        while (rem > 0) begin
            if (cut_kind == 1 && k == cut_at) begin
                idle_gap();
                drive(1'($urandom), 1'($urandom), 1'b1, 16'($urandom), 2'd2, 1'b0);
                push(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 2'd0));
                return;
            end
            if (cut_kind == 2 && k == cut_at) begin
                pend_cancel = 1'b1;
                return;
            end
            li  = (force2 || ($urandom % 4 != 0)) ? 2 : 1;
            out = (li < rem) ? li : rem;
            w   = 16'($urandom);
            send_word(w, 2'(li), 1'b0, 1'($urandom), 1'b1, mk(1'b1, k == 0, 1'b0, 1'b0, w, 2'(out)));
            rem -= out;
            k++;
        end
        repeat (n_pad) send_word(16'($urandom), 2'd2, 1'b0, 1'b0, 1'b0, e);
    endtask

    task automatic reset_and_check(input string tag);
        @(negedge clk);
        nreset = 1'b0;
        bus.valid_i = 1'b0; bus.cancel_i = 1'b0; bus.start_i = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, "_valid_o"},  32'(bus.valid_o),  32'd0);
        chk({tag, "_start_o"},  32'(bus.start_o),  32'd0);
        chk({tag, "_cancel_o"}, 32'(bus.cancel_o), 32'd0);
        chk({tag, "_drop_o"},   32'(bus.drop_o),   32'd0);
        chk({tag, "_len_o"},    32'(bus.len_o),    32'd0);
        chk({tag, "_data_o"},   32'(bus.data_o),   32'd0);
        pend_cancel = 1'b0;
        nreset = 1'b1;
    endtask

    // Monitor: every output event must match the oldest expectation at its exact cycle
    initial begin
        ev_t e;
        bit  ok;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                n_checks++;
                $display("FAIL missing_output: expected event for cycle %0d (v%0b c%0b d%0b), DUT output absent",
                         e.cyc, e.v, e.c, e.d);
            end
            if ((bus.valid_o | bus.drop_o | bus.cancel_o) !== 1'b0 && nreset === 1'b1) begin
                if (q.size() == 0 || q[0].cyc != cyc) begin
                    n_checks++;
                    $display("FAIL unexpected_output @%0d: v%0b s%0b c%0b d%0b data %h len %0d",
                             cyc, bus.valid_o, bus.start_o, bus.cancel_o, bus.drop_o, bus.data_o, bus.len_o);
                end else begin
                    e = q.pop_front();
                    ok = (bus.valid_o === e.v) && (bus.start_o === e.s) &&
                         (bus.cancel_o === e.c) && (bus.drop_o === e.d) &&
                         (!e.v || ((bus.data_o === e.data) && (bus.len_o === e.len)));
                    n_checks++;
                    if (ok) n_pass++;
                    else $display("FAIL out_event @%0d: got v%0b s%0b c%0b d%0b data %h len %0d, expected v%0b s%0b c%0b d%0b data %h len %0d",
                                  cyc, bus.valid_o, bus.start_o, bus.cancel_o, bus.drop_o, bus.data_o, bus.len_o,
                                  e.v, e.s, e.c, e.d, e.data, e.len);
                end
            end
        end
    end

    // Stimulus: directed datagrams first, then randomized mix
    initial begin
        int          kind;
        logic [15:0] d;
        nreset = 1'b0;
        bus.valid_i = 1'b0; bus.start_i = 1'b0; bus.cancel_i = 1'b0;
        bus.data_i = 16'h0; bus.len_i = 2'd0; bus.cs_err_i = 1'b0;
        reset_and_check("reset");

        send_pkt(SRC, DST, 16'd13, 1'b0, 0, 0, 0, 1'b1);
        send_pkt(SRC, 16'd80, 16'd20, 1'b0, 0, 0, 3, 1'b1);
        send_pkt(SRC, DST, 16'd8, 1'b0, 0, 0, 2, 1'b1);
        send_pkt(SRC, DST, 16'd6, 1'b0, 0, 0, 1, 1'b1);
        send_pkt(SRC, DST, 16'd12, 1'b1, 0, 0, 0, 1'b1);
        send_pkt(SRC, DST, 16'd28, 1'b0, 1, 1, 0, 1'b1);
        send_pkt(SRC, DST, 16'd11, 1'b0, 0, 0, 1, 1'b0);
        send_pkt(16'd1234, DST, 16'd12, 1'b0, 0, 0, 0, 1'b1);
        send_pkt(SRC, DST, 16'd20, 1'b0, 2, 2, 0, 1'b1);
        send_pkt(SRC, DST, 16'd14, 1'b0, 3, 0, 0, 1'b1);
        send_pkt(SRC, DST, 16'd9, 1'b0, 0, 0, 0, 1'b1);
        send_pkt(SRC, DST, 16'd24, 1'b0, 2, 1, 0, 1'b1);
        reset_and_check("mid_reset");
        send_pkt(SRC, DST, 16'd10, 1'b0, 0, 0, 0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom % 8);
            case (kind)
                0: send_pkt(SRC, DST, 16'(8 + $urandom_range(0, 20)), 1'b0, 0, 0, int'($urandom % 3), 1'b0);
                1: begin
                    d = 16'($urandom);
                    if (d == DST) d = d ^ 16'h1;
                    send_pkt(SRC, d, 16'(8 + $urandom_range(0, 20)), 1'b0, 0, 0, int'($urandom % 3), 1'b0);
                end
                2: send_pkt(SRC, DST, 16'($urandom % 8), 1'b0, 0, 0, int'($urandom % 3), 1'b0);
                3: send_pkt(SRC, DST, 16'(8 + $urandom_range(0, 20)), 1'b1, 0, 0, 1, 1'b0);
                4: send_pkt(SRC, DST, 16'(8 + $urandom_range(4, 20)), 1'b0, 1, int'($urandom_range(0, 1)), 0, 1'b0);
                5: send_pkt(SRC, DST, 16'(8 + $urandom_range(4, 20)), 1'b0, 2, 1, 0, 1'b0);
                6: send_pkt(SRC, DST, 16'(8 + $urandom_range(0, 20)), 1'b0, 3, 0, 0, 1'b0);
                default: send_pkt(16'($urandom), DST, 16'(8 + $urandom_range(0, 12)), 1'b0, 0, 0, 1, 1'b0);
            endcase
        end
        send_pkt(SRC, DST, 16'd15, 1'b0, 0, 0, 1, 1'b0);

        drive(1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);
        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
